// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexes one BCD-to-one-hot decoder across
// NUM_DIGITS digit positions of a scanned display.
// Frames enter a one-entry pending buffer over valid/ready and move to the
// active register at frame start. Each digit slot is BLANK_CYC blanking
// cycles followed by DWELL show cycles.
// Optional feature: define BCD_SCAN_LZB_EN for leading-zero blanking.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int BLANK_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              dec_in,
  output logic                    dec_valid,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done,
  output logic                    err_bcd,
  input  logic                    err_clr
);

  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int FW   = 4 * NUM_DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  // First state of every digit slot: blanking is skipped entirely when
  // BLANK_CYC is zero.
  localparam logic [1:0] S_SLOT  = (BLANK_CYC > 0) ? S_BLANK : S_SHOW;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [FW-1:0]         act;
  logic [FW-1:0]         pend;
  logic                  pend_full;
  logic                  act_vld;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] lz_next;

  logic [NUM_DIGITS-1:0][3:0] act_dig;
  logic [NUM_DIGITS-1:0][3:0] load_dig;
  logic [NUM_DIGITS-1:0]      dig_bad;
  logic [3:0]                 cur;
  logic                       show;
  logic                       slot_end;
  logic                       last_dig;
  logic                       fstart;
  logic                       xfer;

  assign act_dig  = act;
  assign load_dig = load_data;
  assign cur      = act_dig[idx];

  // Per-digit non-BCD detection on the incoming frame.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_bad
    assign dig_bad[k] = load_dig[k] > 4'd9;
  end

  assign show     = (state == S_SHOW);
  assign slot_end = show && (cnt == SHOW_LAST);
  assign last_dig = (idx == IDX_LAST);
  assign xfer     = load_valid && !pend_full;
  // Frame start: pending frame is promoted to active, either leaving IDLE
  // or back-to-back at the end of the last digit.
  assign fstart   = enable && pend_full &&
                    ((state == S_IDLE) || (slot_end && last_dig));

  assign load_ready = !pend_full;
  assign dec_in     = (state == S_IDLE) ? 4'd0 : cur;
  assign dig_sel    = show ? (NUM_DIGITS'(1) << idx) : '0;
  assign dec_valid  = show && (cur <= 4'd9) && !lz[idx];
  assign frame_done = slot_end && last_dig;

`ifdef BCD_SCAN_LZB_EN
  logic lz_run;
  // Leading-zero mask of the frame about to become active; digit 0 is never
  // masked so an all-zero frame still shows a single "0".
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (pend[4*k +: 4] == 4'd0);
      lz_next[k] = lz_run;
    end
  end
`else
  // Leading-zero blanking compiled out: every valid digit is shown.
  always_comb begin
    lz_next = '0;
  end
`endif

  // Scan sequencer: IDLE -> (BLANK ->) SHOW per digit, wrapping per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_full || act_vld) begin
            state <= S_SLOT;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= S_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= S_SLOT;
            cnt   <= '0;
            idx   <= last_dig ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pending buffer: a new transfer wins over the release at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (xfer) pend <= load_data;
      if (xfer)        pend_full <= 1'b1;
      else if (fstart) pend_full <= 1'b0;
    end
  end

  // Active frame and its leading-zero mask, captured at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= '0;
      lz      <= '0;
      act_vld <= 1'b0;
    end else if (fstart) begin
      act     <= pend;
      lz      <= lz_next;
      act_vld <= 1'b1;
    end
  end

  // Sticky non-BCD flag; a new bad frame beats a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_bcd <= 1'b0;
    else if (xfer && |dig_bad) err_bcd <= 1'b1;
    else if (err_clr)          err_bcd <= 1'b0;
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: directed steps then randomized traffic, every
// cycle checked against a position-in-period reference model.
module tb_bcd_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;
  localparam int B = 1;
  localparam int SLOT = B + D;
  localparam int P = N * SLOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, load_valid, err_clr;
  logic [15:0]   load_data;
  logic          load_ready, dec_valid, frame_done, err_bcd;
  logic [3:0]    dec_in;
  logic [3:0]    dig_sel;

  logic          f_en, f_lv, f_clr;
  logic [15:0]   f_data;
  logic          f_ready, f_valid, f_fd, f_err;
  logic [3:0]    f_in;
  logic [3:0]    f_sel;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .BLANK_CYC(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .dec_in(dec_in),
    .dec_valid(dec_valid), .dig_sel(dig_sel), .frame_done(frame_done),
    .err_bcd(err_bcd), .err_clr(err_clr)
  );

  bcd_scan_ctrl #(.NUM_DIGITS(4), .DWELL(1), .BLANK_CYC(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .enable(f_en), .load_valid(f_lv),
    .load_data(f_data), .load_ready(f_ready), .dec_in(f_in),
    .dec_valid(f_valid), .dig_sel(f_sel), .frame_done(f_fd),
    .err_bcd(f_err), .err_clr(f_clr)
  );

  // Reference model: scanning flag plus position within the scan period.
  logic        m_scan, m_pfull, m_avld, m_err;
  int          m_pos;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_lz;

  function automatic logic [3:0] lz_of(logic [15:0] f);
    logic [3:0] m = '0;
`ifdef BCD_SCAN_LZB_EN
    int msd = 0;
    for (int k = 0; k < 4; k++) if (f[4*k +: 4] != 4'd0) msd = k;
    for (int k = 1; k < 4; k++) if (k > msd) m[k] = 1'b1;
`endif
    return m;
  endfunction

  function automatic logic is_bad(logic [15:0] f);
    logic r = 1'b0;
    for (int k = 0; k < 4; k++) if (f[4*k +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_pos = 0; m_act = '0; m_pend = '0;
    m_pfull = 0; m_avld = 0; m_err = 0; m_lz = '0;
  endtask

  task automatic promote();
    m_act = m_pend; m_lz = lz_of(m_pend); m_pfull = 0; m_avld = 1;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_adv();
    logic x;
    x = load_valid && !m_pfull;
    if (!enable) begin
      m_scan = 0; m_pos = 0;
    end else if (!m_scan) begin
      if (m_pfull) begin promote(); m_scan = 1; m_pos = 0; end
      else if (m_avld) begin m_scan = 1; m_pos = 0; end
    end else if (m_pos == P - 1) begin
      m_pos = 0;
      if (m_pfull) promote();
    end else begin
      m_pos++;
    end
    if (x) begin m_pend = load_data; m_pfull = 1; end
    if (x && is_bad(load_data)) m_err = 1;
    else if (err_clr)           m_err = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int slot, off;
    logic show;
    logic [3:0] dg;
    slot = m_pos / SLOT;
    off  = m_pos % SLOT;
    show = m_scan && (off >= B);
    dg   = 4'((m_act >> (4 * slot)) & 16'hF);
    chk("load_ready", 32'(load_ready), 32'(!m_pfull));
    chk("dec_in",     32'(dec_in),     m_scan ? 32'(dg) : 32'd0);
    chk("dig_sel",    32'(dig_sel),    show ? (32'd1 << slot) : 32'd0);
    chk("dec_valid",  32'(dec_valid),  32'(show && dg <= 4'd9 && !m_lz[slot]));
    chk("frame_done", 32'(frame_done), 32'(show && m_pos == P - 1));
    chk("err_bcd",    32'(err_bcd),    32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_adv();
    #1;
    check_all();
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (load_ready) break;
      cyc();
    end
    chk(tag, 32'(load_ready), 32'd1);
  endtask

  task automatic load(input logic [15:0] d);
    wait_ready("load_wait");
    load_valid = 1'b1; load_data = d;
    cyc();
    load_valid = 1'b0;
  endtask

  initial begin
    int fd_at;
    logic seen;
    rst_n = 0; enable = 0; load_valid = 0; load_data = '0; err_clr = 0;
    f_en = 0; f_lv = 0; f_data = '0; f_clr = 0;
    model_reset();
    #3;
    check_all();
    chk("fast_reset_ready", 32'(f_ready), 32'd1);
    chk("fast_reset_sel", 32'(f_sel), 32'd0);
    @(negedge clk); rst_n = 1;

    // No blanking, one-cycle dwell: digit select rotates every cycle.
    f_en = 1; f_lv = 1; f_data = 16'h1234;
    cyc();
    f_lv = 0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("fast_sel", 32'(f_sel), 32'd1 << (i % 4));
      chk("fast_fd", 32'(f_fd), 32'((i % 4) == 3));
      chk("fast_in", 32'(f_in), 32'(4 - (i % 4)));
      cyc();
    end
    f_en = 0;

    // Basic frame 1234: ready drops after transfer, 5-cycle slots.
    enable = 1; load_valid = 1; load_data = 16'h1234;
    cyc();
    load_valid = 0;
    chk("ready_drop", 32'(load_ready), 32'd0);
    fd_at = 0;
    for (int i = 1; i <= P; i++) begin
      cyc();
      if (frame_done) fd_at = i;
      if ((i - 1) % SLOT == 0) begin
        chk("blank_sel", 32'(dig_sel), 32'd0);
      end else begin
        chk("show_sel", 32'(dig_sel), 32'd1 << ((i - 1) / SLOT));
        chk("show_in", 32'(dec_in), 32'(4 - (i - 1) / SLOT));
      end
    end
    chk("fd_cycle", 32'(fd_at), 32'd20);

    // Mid-frame loads: the second stalls until frame start, then 5678 shows.
    repeat (3) cyc();
    load_valid = 1; load_data = 16'h5678;
    cyc();
    load_data = 16'h8765;
    chk("stall_ready", 32'(load_ready), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (frame_done) begin seen = 1; break; end
    end
    chk("fd_seen", 32'(seen), 32'd1);
    cyc(); cyc();
    load_valid = 0;
    chk("next_first_in", 32'(dec_in), 32'h8);
    chk("next_first_sel", 32'(dig_sel), 32'd1);

    // Non-BCD flag, clear, and set-beats-clear.
    load(16'h12A4);
    chk("err_set", 32'(err_bcd), 32'd1);
    err_clr = 1; cyc(); err_clr = 0;
    chk("err_clr", 32'(err_bcd), 32'd0);
    wait_ready("bad2_wait");
    load_valid = 1; load_data = 16'hF000; err_clr = 1;
    cyc();
    load_valid = 0; err_clr = 0;
    chk("err_prio", 32'(err_bcd), 32'd1);
    repeat (50) cyc();

    // Enable drop during digit 2, then re-enable restarts at digit 0.
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (dig_sel == 4'b0100) begin seen = 1; break; end
      cyc();
    end
    chk("dig2_seen", 32'(seen), 32'd1);
    enable = 0; cyc();
    chk("dis_sel", 32'(dig_sel), 32'd0);
    repeat (3) cyc();
    enable = 1; cyc(); cyc();
    chk("reen_sel", 32'(dig_sel), 32'd1);

    // Asynchronous reset mid-scan.
    repeat (7) cyc();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_sel", 32'(dig_sel), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd1);
    check_all();
    @(negedge clk); rst_n = 1;

    // Leading-zero frames (blanked only when the feature is built in).
    load(16'h0040);
    repeat (45) cyc();
    load(16'h0000);
    repeat (45) cyc();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) d[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) d[15:8] = 8'h00;
      load_data  = d;
      load_valid = ($urandom_range(0, 3) == 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      enable     = ($urandom_range(0, 39) != 0);
      cyc();
    end
    load_valid = 0; err_clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
